// File: rtl/uvma_clk_mc_gen.sv
// uvma_clk_mc_gen: NUM_CH independently programmable divided clocks with phase offset and glitch-free start/stop
module uvma_clk_mc_gen #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned DEF_HALF_PERIOD = 5,
    localparam int unsigned CH_W           = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half_period,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] rise_strb
);
    typedef enum logic [1:0] {IDLE, PHASE, RUN, STOPPING} state_t;
    logic cfg_err_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cfg_err_q <= 1'b0;
        else cfg_err_q <= cfg_we && 32'(cfg_ch) >= NUM_CH;
    end
    assign cfg_err = cfg_err_q;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, hp_q, hp_d, sh_hp_q, sh_hp_d, sh_ph_q, sh_ph_d, hp_eff;
        logic clk_q, clk_d, rise_q, rise_d, wr, tick;
        assign wr     = cfg_we && 32'(cfg_ch) == g;
        assign hp_eff = sh_hp_q == '0 ? CNT_W'(1) : sh_hp_q;
        assign tick   = cnt_q == CNT_W'(1);
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                hp_q    <= CNT_W'(DEF_HALF_PERIOD);
                sh_hp_q <= CNT_W'(DEF_HALF_PERIOD);
                sh_ph_q <= '0;
                clk_q   <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hp_q    <= hp_d;
                sh_hp_q <= sh_hp_d;
                sh_ph_q <= sh_ph_d;
                clk_q   <= clk_d;
                rise_q  <= rise_d;
            end
        end
        // A stop in RUN lets the current high and the following low finish; the channel idles where the next rise would be
        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:     if (start[g] && !stop[g]) state_d = sh_ph_q == '0 ? RUN : PHASE;
                PHASE:    if (stop[g]) state_d = IDLE; else if (tick) state_d = RUN;
                RUN:      if (stop[g]) state_d = tick && !clk_q ? IDLE : STOPPING;
                STOPPING: if (tick && !clk_q) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
        always_comb begin
            rise_d  = state_d == RUN && (state_q != RUN || (tick && !clk_q));
            clk_d   = rise_d ? 1'b1 : (state_d == IDLE || (tick && clk_q)) ? 1'b0 : clk_q;
            cnt_d   = rise_d ? hp_eff :
                      (state_q == IDLE && state_d == PHASE) ? sh_ph_q :
                      state_d == IDLE ? '0 :
                      tick ? hp_q : cnt_q - CNT_W'(1);
            hp_d    = (rise_d || state_q == IDLE) ? hp_eff : hp_q;
            sh_hp_d = wr ? cfg_half_period : sh_hp_q;
            sh_ph_d = wr ? cfg_phase : sh_ph_q;
        end
        assign clk_out[g]   = clk_q;
        assign running[g]   = state_q != IDLE;
        assign rise_strb[g] = rise_q;
    end
endmodule
